// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the interrupt controller slice:
//   - irq_state_e       : controller FSM state encoding (IDLE / TAKE / RET)
//   - DEF_VECTOR_BASE   : default handler address of source 0
//   - DEF_VECTOR_STRIDE : default spacing between handler entries
//   - vector_addr()     : handler address for a source index (32-bit wrap)
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAKE = 2'd1,
    ST_RET  = 2'd2
  } irq_state_e;

  localparam logic [31:0] DEF_VECTOR_BASE   = 32'h0000_0800;
  localparam logic [31:0] DEF_VECTOR_STRIDE = 32'h0000_0010;

  function automatic logic [31:0] vector_addr(input logic [31:0] base,
                                              input logic [31:0] stride,
                                              input logic [3:0]  idx);
    return base + stride * {28'd0, idx};
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// -----------------------------------------------------------------------------
// irq_priority_encoder
// Selects the highest-index asserted request line.
// Ports:
//   req   [N-1:0] in  : request vector (bit k has priority k)
//   valid         out : at least one request asserted
//   idx   [3:0]   out : index of the winning request (0 when !valid)
// -----------------------------------------------------------------------------
module irq_priority_encoder #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [3:0]   idx
);

  // Ascending scan: the last asserted bit seen is the highest index.
  always_comb begin
    valid = 1'b0;
    idx   = 4'd0;
    for (int k = 0; k < N; k++) begin
      if (req[k]) begin
        valid = 1'b1;
        idx   = 4'(k);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
// Nested, priority-based exception controller. Rising edges on ExpSrc latch
// pending requests; the highest enabled pending source above the current
// in-service priority is taken (PC pushed, vector issued). Eret pops a level.
//
// Ports:
//   Clock                 in  : sole clock, rising edge
//   Reset_n               in  : synchronous active-low reset
//   ExpSrc   [NUM_SRC]    in  : request lines, rising edge raises a request
//   MaskWe / MaskIn       in  : mask write strobe / data (1 = enabled)
//   ReturnPC [32]         in  : PC saved on entry
//   Eret                  in  : return from innermost handler (pulse)
//   TakeExp               out : one-cycle pulse, CPU loads VectorPC
//   VectorPC [32]         out : handler address, valid with TakeExp
//   EpcOut   [32]         out : saved PC of innermost level (0 at Depth=0)
//   Pending  [NUM_SRC]    out : latched, not-yet-serviced requests
//   Depth    [4]          out : current nesting level
//   Overflow              out : sticky, request blocked by full nest depth
//   TakeCount[NUM_SRC*32] out : per-source saturating take counts
//                               (only with IRQ_COUNTERS_EN defined)
//
// Build option: define IRQ_COUNTERS_EN to add the TakeCount port and counters.
// -----------------------------------------------------------------------------
module interrupt_controller #(
  parameter int          NUM_SRC       = 3,
  parameter int          NEST_DEPTH    = 3,
  parameter logic [31:0] VECTOR_BASE   = cpu_pkg::DEF_VECTOR_BASE,
  parameter logic [31:0] VECTOR_STRIDE = cpu_pkg::DEF_VECTOR_STRIDE
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic [NUM_SRC-1:0]   ExpSrc,
  input  logic                 MaskWe,
  input  logic [NUM_SRC-1:0]   MaskIn,
  input  logic [31:0]          ReturnPC,
  input  logic                 Eret,
  output logic                 TakeExp,
  output logic [31:0]          VectorPC,
  output logic [31:0]          EpcOut,
  output logic [NUM_SRC-1:0]   Pending,
  output logic [3:0]           Depth,
  output logic                 Overflow
`ifdef IRQ_COUNTERS_EN
  ,
  output logic [NUM_SRC*32-1:0] TakeCount
`endif
);

  import cpu_pkg::*;

  // Stack is sized to a power of two so the depth counter's low bits address
  // it directly; modular pointer arithmetic then gives the top entry.
  localparam int         PTR_W    = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
  localparam int         STK_N    = 1 << PTR_W;
  localparam logic [3:0] NEST_MAX = 4'(NEST_DEPTH);

  irq_state_e             state_q, state_d;
  logic [NUM_SRC-1:0]     exp_src_p0;
  logic [NUM_SRC-1:0]     pending_q;
  logic [NUM_SRC-1:0]     mask_q;
  logic [3:0]             depth_q;
  logic                   overflow_q;
  logic [3:0]             take_idx_q;
  logic [31:0]            stack_pc  [STK_N];
  logic [3:0]             stack_idx [STK_N];

  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic signed [5:0]      cur_pri;
  logic [NUM_SRC-1:0]     rise;
  logic [NUM_SRC-1:0]     eligible;
  logic [NUM_SRC-1:0]     win_clr;
  logic                   enc_valid;
  logic [3:0]             enc_idx;
  logic                   eret_ok;
  logic                   do_push, do_pop;

  assign wr_ptr  = depth_q[PTR_W-1:0];
  assign rd_ptr  = wr_ptr - PTR_W'(1);
  assign cur_pri = (depth_q == 4'd0) ? -6'sd1 : $signed({2'b00, stack_idx[rd_ptr]});
  assign rise    = ExpSrc & ~exp_src_p0;
  assign eret_ok = Eret && (depth_q != 4'd0);

  always_comb begin
    eligible = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      eligible[k] = pending_q[k] & mask_q[k] & ($signed(6'(k)) > cur_pri);
    end
  end

  irq_priority_encoder #(
    .N (NUM_SRC)
  ) u_prio (
    .req   (eligible),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // ---- FSM: state register ----
  always_ff @(posedge Clock) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // ---- FSM: next state (Eret wins over a simultaneous take) ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (eret_ok)                              state_d = ST_RET;
        else if (enc_valid && depth_q < NEST_MAX) state_d = ST_TAKE;
      end
      ST_TAKE: state_d = ST_IDLE;
      ST_RET:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs / transition strobes ----
  always_comb begin
    TakeExp = (state_q == ST_TAKE);
    do_push = (state_q == ST_IDLE) && (state_d == ST_TAKE);
    do_pop  = (state_q == ST_IDLE) && (state_d == ST_RET);
    win_clr = do_push ? (NUM_SRC'(1) << enc_idx) : '0;
  end

  // ---- Stage p0: edge capture, pending/mask, nest stack ----
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      exp_src_p0 <= '0;
      pending_q  <= '0;
      mask_q     <= '1;
      depth_q    <= 4'd0;
      overflow_q <= 1'b0;
      take_idx_q <= 4'd0;
      for (int i = 0; i < STK_N; i++) begin
        stack_pc[i]  <= 32'd0;
        stack_idx[i] <= 4'd0;
      end
    end else begin
      exp_src_p0 <= ExpSrc;
      if (MaskWe) mask_q <= MaskIn;
      // A fresh edge on the winner in its clear cycle keeps it pending.
      pending_q  <= (pending_q & ~win_clr) | rise;
      if ((state_q == ST_IDLE) && enc_valid && (depth_q == NEST_MAX))
        overflow_q <= 1'b1;
      if (do_push) begin
        stack_pc[wr_ptr]  <= ReturnPC;
        stack_idx[wr_ptr] <= enc_idx;
        take_idx_q        <= enc_idx;
        depth_q           <= depth_q + 4'd1;
      end else if (do_pop) begin
        depth_q <= depth_q - 4'd1;
      end
    end
  end

  assign VectorPC = vector_addr(VECTOR_BASE, VECTOR_STRIDE, take_idx_q);
  assign EpcOut   = (depth_q != 4'd0) ? stack_pc[rd_ptr] : 32'd0;
  assign Pending  = pending_q;
  assign Depth    = depth_q;
  assign Overflow = overflow_q;

`ifdef IRQ_COUNTERS_EN
  logic [31:0] take_cnt [NUM_SRC];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // ---- Stage p1: per-source take counters ----
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      for (int k = 0; k < NUM_SRC; k++) take_cnt[k] <= 32'd0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if ((state_q == ST_TAKE) && (take_idx_q == 4'(k)))
          take_cnt[k] <= sat_inc(take_cnt[k]);
      end
    end
  end

  always_comb begin
    TakeCount = '0;
    for (int k = 0; k < NUM_SRC; k++) TakeCount[k*32 +: 32] = take_cnt[k];
  end
`endif

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3: number of external exception sources (1..16).
REQ-002 SHALL have parameter NEST_DEPTH, default 3: maximum nested in-service levels (1..8).
REQ-003 SHALL have parameter VECTOR_BASE, default 32'h00000800: handler address of source 0.
REQ-004 SHALL have parameter VECTOR_STRIDE, default 32'h00000010: address spacing between handler entries.
REQ-005 SHALL have port Clock  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port Reset_n  input  1  synchronous active-low reset.
REQ-007 SHALL have port ExpSrc  input  NUM_SRC  asynchronous-free level request lines; a rising edge raises a request.
REQ-008 SHALL have port MaskWe  input  1  write strobe for the mask register.
REQ-009 SHALL have port MaskIn  input  NUM_SRC  mask data; bit=1 enables that source.
REQ-010 SHALL have port ReturnPC  input  32  PC to save on entry.
REQ-011 SHALL have port Eret  input  1  one-cycle pulse requesting return from the innermost handler.
REQ-012 SHALL have port TakeExp  output  1  one-cycle pulse: the CPU shall load VectorPC.
REQ-013 SHALL have port VectorPC  output  32  handler address, valid when TakeExp=1.
REQ-014 SHALL have port EpcOut  output  32  saved PC of the innermost level; valid while Depth>0.
REQ-015 SHALL have port Pending  output  NUM_SRC  latched, not-yet-serviced requests.
REQ-016 SHALL have port Depth  output  4  current nesting level.
REQ-017 SHALL have port Overflow  output  1  sticky; set when a request is blocked only by full nest depth.

Function
REQ-018 SHALL register ExpSrc once and set Pending[k] on a 0->1 transition; request at cycle n is visible in Pending at n+1.
REQ-019 SHALL give source k priority k (higher index wins); in-service priority is -1 when Depth=0.
REQ-020 SHALL consider source k eligible when Pending[k]&Mask[k] and k > current in-service priority.
REQ-021 SHALL use FSM states IDLE, TAKE, RET; IDLE->TAKE when any source is eligible and Depth<NEST_DEPTH; IDLE->RET on Eret with Depth>0; TAKE and RET return to IDLE after one cycle.
REQ-022 SHALL, on entering TAKE, push {ReturnPC, winning index} onto the nest stack, clear Pending of the winner, increment Depth, and assert TakeExp with VectorPC = VECTOR_BASE + index*VECTOR_STRIDE (32-bit wrap) for exactly that cycle.
REQ-023 SHALL, on entering RET, pop the stack, decrement Depth, and restore in-service priority to the popped-below entry.
REQ-024 SHALL give Eret precedence when Eret and an eligible request occur in the same IDLE cycle; the request is re-evaluated next IDLE cycle.
REQ-025 SHALL ignore Eret when Depth=0 (no state change).
REQ-026 SHALL keep Pending[k]=1 if a new edge on k arrives in the same cycle its pending bit is cleared.
REQ-027 SHALL set Overflow when an eligible request exists, Depth=NEST_DEPTH and FSM is IDLE; pending is retained.
REQ-028 SHALL apply MaskWe in the same cycle regardless of FSM state; the new mask governs eligibility from the next cycle.

Reset
REQ-029 SHALL on Reset_n=0 at a rising edge clear Pending, Mask (all enabled = all ones), stack, Depth=0, Overflow=0, EpcOut=0, TakeExp=0, VectorPC=VECTOR_BASE, FSM=IDLE, edge registers = 0.
REQ-030 SHALL abort any TAKE/RET in progress when reset is asserted; no push/pop completes.

Configuration
REQ-031 SHALL, with IRQ_COUNTERS_EN defined, provide output TakeCount (NUM_SRC*32 bits): per-source saturating 32-bit counts of TakeExp events, cleared by reset.
REQ-032 SHALL, without IRQ_COUNTERS_EN, omit TakeCount port and counter logic entirely.

Structure
REQ-033 SHALL place FSM state encoding and default VECTOR_BASE/VECTOR_STRIDE constants in shared package cpu_pkg.
REQ-034 SHALL implement the priority select as sub-module irq_priority_encoder (NUM_SRC-wide, returns valid + index).

Verification
REQ-035 SHALL test: reset, ExpSrc[0] rises -> TakeExp at cycle n+2, VectorPC=32'h800, Depth=1, EpcOut=ReturnPC.
REQ-036 SHALL test: sources 0 and 2 rise together -> source 2 taken first (VectorPC=32'h820), source 0 taken only after Eret.
REQ-037 SHALL test: in-service source 1, source 2 rises -> nested take, Depth=2; two Erets restore EpcOut in LIFO order, Depth=0.
REQ-038 SHALL test: NEST_DEPTH=1, in-service 0, source 2 rises -> no TakeExp, Overflow=1, Pending[2]=1.
REQ-039 SHALL test: Mask=3'b110, source 0 rises -> Pending[0]=1, no take; MaskIn=3'b111 -> take two cycles later.
REQ-040 SHALL test: Eret and eligible request in same cycle -> RET first, TakeExp one IDLE cycle later; Reset_n low mid-TAKE -> all outputs reset values.
